core_seq_ctrl: RTL and testbench

- Read sequencer for one compute core. It issues paired weight-buffer (lbuf) and activation-buffer (abuf) reads that feed the core MAC/ACC/quant pipeline.
- For each of cfg_out_num outputs it issues exactly cfg_acc_num read pairs, gated by buffer empty flags.
- Optionally replays the activation vector via the abuf reuse port, then drains the pipeline and signals completion.
- Sits between the cluster-level controller (start/done) and one core's buffer read ports.

---
 rtl/core_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Read sequencer for one compute core: issues paired lbuf/abuf reads for
// cfg_out_num outputs of cfg_acc_num pairs each, then drains and pulses done.
module core_seq_ctrl #(
  parameter int CDATA_BIT = 8,
  parameter int OCNT_BIT  = 12,
  parameter int DRAIN_CYC = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CDATA_BIT-1:0] cfg_acc_num,
  input  logic [OCNT_BIT-1:0]  cfg_out_num,
  input  logic                 cfg_reuse,
  input  logic                 lbuf_empty,
  input  logic                 abuf_empty,
  input  logic                 abuf_reuse_empty,
  output logic                 lbuf_ren,
  output logic                 abuf_ren,
  output logic                 abuf_reuse_ren,
  output logic                 abuf_reuse_rst,
  output logic                 busy,
  output logic                 done,
  output logic [CDATA_BIT-1:0] word_cnt,
  output logic [OCNT_BIT-1:0]  out_cnt
);

  // state | meaning
  // IDLE  | waiting for start; the accepted start is acted on one cycle later
  // FETCH | issuing read pairs for the current output
  // NEXT  | one-cycle bubble between outputs, rewinds the reuse pointer
  // DRAIN | waiting for the MAC/ACC/quant pipeline to empty
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_NEXT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYC - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_start_q;
  logic [CDATA_BIT-1:0] r_acc_num;
  logic [OCNT_BIT-1:0]  r_out_num;
  logic                 r_reuse;
  logic [CDATA_BIT-1:0] r_word_cnt;
  logic [OCNT_BIT-1:0]  r_out_cnt;
  logic [7:0]           r_drain_cnt;

  logic w_start_acc;
  logic w_use_abuf;
  logic w_src_empty;
  logic w_issue;
  logic w_word_last;
  logic w_out_last;
  logic w_cfg_zero;

  // Start is accepted only in IDLE and only once per launch.
  assign w_start_acc = (r_state == ST_IDLE) && start && !r_start_q;
  assign w_use_abuf  = (r_out_cnt == '0) || !r_reuse;
  assign w_src_empty = w_use_abuf ? abuf_empty : abuf_reuse_empty;
  assign w_issue     = (r_state == ST_FETCH) && !lbuf_empty && !w_src_empty;
  assign w_word_last = (r_word_cnt == (r_acc_num - CDATA_BIT'(1)));
  assign w_out_last  = (r_out_cnt == (r_out_num - OCNT_BIT'(1)));
  assign w_cfg_zero  = (r_acc_num == '0) || (r_out_num == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    lbuf_ren       = 1'b0;
    abuf_ren       = 1'b0;
    abuf_reuse_ren = 1'b0;
    abuf_reuse_rst = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (r_start_q) begin
          w_state_nxt = w_cfg_zero ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        lbuf_ren       = w_issue;
        abuf_ren       = w_issue && w_use_abuf;
        abuf_reuse_ren = w_issue && !w_use_abuf;
        if (w_issue && w_word_last) begin
          w_state_nxt = w_out_last ? ST_DRAIN : ST_NEXT;
        end
      end
      ST_NEXT: begin
        abuf_reuse_rst = r_reuse;
        w_state_nxt    = ST_FETCH;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == 8'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_start_q <= 1'b0;
      r_acc_num <= '0;
      r_out_num <= '0;
      r_reuse   <= 1'b0;
    end else begin
      r_start_q <= w_start_acc;
      if (w_start_acc) begin
        r_acc_num <= cfg_acc_num;
        r_out_num <= cfg_out_num;
        r_reuse   <= cfg_reuse;
      end
    end
  end

  // Counters hold on stalled cycles; the word counter parks at acc_num-1
  // after the final pair so it never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_word_cnt <= '0;
      r_out_cnt  <= '0;
    end else if (w_start_acc) begin
      r_word_cnt <= '0;
      r_out_cnt  <= '0;
    end else if (w_issue) begin
      if (!w_word_last) begin
        r_word_cnt <= r_word_cnt + CDATA_BIT'(1);
      end else if (!w_out_last) begin
        r_word_cnt <= '0;
        r_out_cnt  <= r_out_cnt + OCNT_BIT'(1);
      end
    end
  end

  // Drain timer: down-counter loaded on the last pair, terminal count at 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drain_cnt <= 8'd0;
    end else if (w_issue && w_word_last && w_out_last) begin
      r_drain_cnt <= DRAIN_LOAD;
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != 8'd0)) begin
      r_drain_cnt <= r_drain_cnt - 8'd1;
    end
  end

  assign word_cnt = r_word_cnt;
  assign out_cnt  = r_out_cnt;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: cycle-exact timing, reuse, stalls,
// zero-length jobs, ignored starts and mid-job reset.
module tb_core_seq_ctrl;

  localparam int CB = 8;
  localparam int OB = 12;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [CB-1:0] cfg_acc_num = '0;
  logic [OB-1:0] cfg_out_num = '0;
  logic          cfg_reuse = 1'b0;
  logic          lbuf_empty = 1'b0;
  logic          abuf_empty = 1'b0;
  logic          abuf_reuse_empty = 1'b0;
  logic          lbuf_ren, abuf_ren, abuf_reuse_ren, abuf_reuse_rst, busy, done;
  logic [CB-1:0] word_cnt;
  logic [OB-1:0] out_cnt;

  int errors = 0;
  int checks = 0;
  int n_l = 0, n_a = 0, n_r = 0, n_rst = 0, n_done = 0, n_busy = 0, n_viol = 0;
  int s_l, s_a, s_r, s_rst, s_done, s_busy;
  int cyc;
  logic [CB-1:0] prev_w;
  logic [OB-1:0] prev_o;
  logic          was_stall;

  core_seq_ctrl #(.CDATA_BIT(CB), .OCNT_BIT(OB), .DRAIN_CYC(D)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_acc_num(cfg_acc_num), .cfg_out_num(cfg_out_num), .cfg_reuse(cfg_reuse),
    .lbuf_empty(lbuf_empty), .abuf_empty(abuf_empty), .abuf_reuse_empty(abuf_reuse_empty),
    .lbuf_ren(lbuf_ren), .abuf_ren(abuf_ren), .abuf_reuse_ren(abuf_reuse_ren),
    .abuf_reuse_rst(abuf_reuse_rst), .busy(busy), .done(done),
    .word_cnt(word_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  // Strobe/pulse tally and pairing/stall legality, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (lbuf_ren) n_l++;
      if (abuf_ren) n_a++;
      if (abuf_reuse_ren) n_r++;
      if (abuf_reuse_rst) n_rst++;
      if (done) n_done++;
      if (busy) n_busy++;
      if ((abuf_ren && abuf_reuse_ren) || (lbuf_ren != (abuf_ren || abuf_reuse_ren))) n_viol++;
      if ((lbuf_ren && lbuf_empty) || (abuf_ren && abuf_empty) ||
          (abuf_reuse_ren && abuf_reuse_empty)) n_viol++;
      if (abuf_reuse_rst && (lbuf_ren || abuf_ren || abuf_reuse_ren)) n_viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_l = n_l; s_a = n_a; s_r = n_r; s_rst = n_rst; s_done = n_done; s_busy = n_busy;
  endtask

  // Ticks until done is seen; returns the tick count, or -1 on timeout.
  task automatic run_until_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic launch(input int acc, input int outs, input logic reuse);
    cfg_acc_num = CB'(acc);
    cfg_out_num = OB'(outs);
    cfg_reuse   = reuse;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_lbuf_ren", lbuf_ren, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_out_cnt", out_cnt, 0);
    tick();
    rstn = 1'b1;
    tick();
    tick();

    // Job 1: acc=4 out=1 reuse=0, no stalls, cycle-exact
    snap();
    launch(4, 1, 1'b0);                 // now in cycle 1
    check("j1_c1_busy", busy, 0);
    check("j1_c1_lbuf", lbuf_ren, 0);
    tick();
    for (int c = 2; c <= 5; c++) begin
      check("j1_fetch_lbuf", lbuf_ren, 1);
      check("j1_fetch_abuf", abuf_ren, 1);
      check("j1_fetch_word", word_cnt, c - 2);
      tick();
    end
    check("j1_c6_lbuf", lbuf_ren, 0);
    check("j1_c6_busy", busy, 1);
    run_until_done(100, cyc);
    check("j1_done_cycle", cyc + 6, 6 + D);
    tick();
    check("j1_after_done", done, 0);
    check("j1_after_busy", busy, 0);
    check("j1_pairs", n_l - s_l, 4);
    check("j1_abuf", n_a - s_a, 4);
    check("j1_reuse", n_r - s_r, 0);
    check("j1_done_cnt", n_done - s_done, 1);

    // Job 2: acc=3 out=3 reuse=1
    tick();
    snap();
    launch(3, 3, 1'b1);
    tick();
    for (int c = 2; c <= 12; c++) begin
      if (c == 3) check("j2_c3_out", out_cnt, 0);
      if (c == 4) check("j2_c4_word", word_cnt, 2);
      if (c == 5) check("j2_c5_rst", abuf_reuse_rst, 1);
      if (c == 5) check("j2_c5_lbuf", lbuf_ren, 0);
      if (c == 6) check("j2_c6_reuse_ren", abuf_reuse_ren, 1);
      if (c == 6) check("j2_c6_abuf", abuf_ren, 0);
      if (c == 7) check("j2_c7_out", out_cnt, 1);
      if (c == 9) check("j2_c9_rst", abuf_reuse_rst, 1);
      if (c == 11) check("j2_c11_out", out_cnt, 2);
      tick();
    end
    run_until_done(100, cyc);
    check("j2_done_seen", cyc >= 0, 1);
    tick();
    check("j2_abuf", n_a - s_a, 3);
    check("j2_reuse", n_r - s_r, 6);
    check("j2_lbuf", n_l - s_l, 9);
    check("j2_rst_pulses", n_rst - s_rst, 2);
    check("j2_done_cnt", n_done - s_done, 1);

    // Job 3: acc=4 out=2 reuse=0, lbuf_empty toggling every cycle
    tick();
    snap();
    launch(4, 2, 1'b0);
    cyc = 0;
    while (!done && cyc < 200) begin
      lbuf_empty = ~lbuf_empty;
      was_stall  = lbuf_empty;
      prev_w     = word_cnt;
      prev_o     = out_cnt;
      tick();
      cyc++;
      if (was_stall) begin
        check("j3_stall_word", word_cnt, prev_w);
        check("j3_stall_out", out_cnt, prev_o);
      end
    end
    check("j3_done_seen", done, 1);
    lbuf_empty = 1'b0;
    tick();
    check("j3_pairs", n_l - s_l, 8);
    check("j3_abuf", n_a - s_a, 8);
    check("j3_done_cnt", n_done - s_done, 1);

    // Job 4: acc_num=0
    tick();
    snap();
    launch(0, 5, 1'b0);
    check("j4_c1_done", done, 0);
    tick();
    check("j4_c2_done", done, 1);
    tick();
    check("j4_c3_done", done, 0);
    tick();
    check("j4_reads", n_l - s_l, 0);
    check("j4_busy_cycles", n_busy - s_busy, 1);

    // Job 5: acc=8 out=4, restart and cfg change mid-job ignored
    tick();
    snap();
    launch(8, 4, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    cfg_acc_num = 8'd2;
    cfg_out_num = 12'd1;
    cfg_reuse   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(500, cyc);
    check("j5_done_seen", cyc >= 0, 1);
    start = 1'b1;                       // start in the DONE cycle
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("j5_no_restart", busy, 0);
    check("j5_pairs", n_l - s_l, 32);
    check("j5_abuf", n_a - s_a, 32);
    check("j5_reuse", n_r - s_r, 0);
    check("j5_done_cnt", n_done - s_done, 1);

    // Job 6: reset mid-job at word_cnt=2, then a clean job
    tick();
    launch(4, 1, 1'b0);
    tick();
    tick();
    tick();
    check("j6_word_pre", word_cnt, 2);
    rstn = 1'b0;
    #1;
    check("j6_rst_lbuf", lbuf_ren, 0);
    check("j6_rst_abuf", abuf_ren, 0);
    check("j6_rst_busy", busy, 0);
    check("j6_rst_word", word_cnt, 0);
    check("j6_rst_done", done, 0);
    tick();
    tick();
    rstn = 1'b1;
    snap();
    for (int i = 0; i < 4; i++) tick();
    check("j6_release_done", n_done - s_done, 0);
    check("j6_release_busy", busy, 0);
    snap();
    launch(4, 1, 1'b0);
    run_until_done(100, cyc);
    check("j6_job_done", cyc >= 0, 1);
    tick();
    check("j6_pairs", n_l - s_l, 4);
    check("j6_done_cnt", n_done - s_done, 1);

    check("pair_violations", n_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
